skid_reg: RTL and testbench
===========================

SKID_REG -- requirements
Module: skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all held data.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream offers in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a payload this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the payload presented downstream.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts out_data this cycle.
REQ-011 The block SHALL have port count, output, 2 bits: occupancy, in the range 0 to 2.

Function
REQ-012 An input transfer SHALL occur exactly when in_valid and in_ready are both 1 at a rising edge of CLK.
REQ-013 An output transfer SHALL occur exactly when out_valid and out_ready are both 1 at a rising edge of CLK.
REQ-014 State SHALL be one of EMPTY (count 0), ONE (count 1) or FULL (count 2), held in a main register and a skid register.
REQ-015 in_ready SHALL equal (state != FULL), decoded from state only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL equal (state != EMPTY), and out_data SHALL always be the main register.
REQ-017 In EMPTY, on an input transfer, the block SHALL load main with in_data and go to ONE; otherwise it SHALL stay in EMPTY.
REQ-018 In ONE, on simultaneous input and output transfers, the block SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, on an input transfer only, the block SHALL load skid with in_data and go to FULL, leaving main unchanged.
REQ-020 In ONE, on an output transfer only, the block SHALL go to EMPTY.
REQ-021 In FULL, on an output transfer, the block SHALL copy skid to main and go to ONE; in_data SHALL be ignored that cycle because in_ready is 0.
REQ-022 Latency SHALL be 1 cycle: data accepted at edge N SHALL be presented on out_data after edge N when the block was EMPTY.
REQ-023 Sustained throughput SHALL be one payload per cycle while out_ready is held at 1.
REQ-024 Ordering SHALL be strictly FIFO, with no payload duplicated or dropped except by flush or reset.
REQ-025 While out_valid is 1 and out_ready is 0, out_data SHALL remain stable.
REQ-026 flush=1 at an edge SHALL force the block to EMPTY and discard any input transfer in the same cycle; flush SHALL override all transfers.
REQ-027 count SHALL be decoded from state as 0, 1 or 2; the value 3 SHALL never appear.

Reset
REQ-028 reset=0 at a rising edge SHALL force state EMPTY, giving in_ready=1, out_valid=0 and count=0.
REQ-029 reset=0 at a rising edge SHALL clear main and skid to 0, giving out_data=0.
REQ-030 reset SHALL take priority over flush and over all transfers, including when asserted mid-stream.
REQ-031 Reset SHALL have no asynchronous path.

Structure
REQ-032 The state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) SHALL reside in the shared project package and be reused for count.
REQ-033 The main and skid registers SHALL each be an instance of a sub-module reg_en_rn: a WIDTH-bit register with load enable and synchronous active-low clear.
REQ-034 The next-state and enable logic SHALL be a single combinational process in skid_reg.

Verification
REQ-035 Reset scenario: hold reset=0 for 2 cycles with in_valid=1 and in_data=0xAA -> count=0, out_valid=0, in_ready=1 and out_data=0x00 after release.
REQ-036 Streaming scenario: out_ready=1 with inputs 0x01,0x02,0x03 on consecutive cycles -> out_data shows 0x01,0x02,0x03 on consecutive cycles, each 1 cycle after its input, and count stays 1.
REQ-037 Backpressure scenario: out_ready=0 with inputs 0x10 then 0x20 -> count=2 and in_ready=0; offering 0x30 next -> not accepted; then out_ready=1 -> outputs 0x10, 0x20, then 0x30.
REQ-038 FULL-drain scenario: in FULL, out_ready=1 with in_valid=1 and in_data=0x55 -> 0x55 not accepted that cycle, count goes to 1, out_data equals the former skid value.
REQ-039 Flush scenario: in FULL, assert flush with in_valid=1 and in_data=0x77 -> count=0 next cycle, out_valid=0, and 0x77 is never output.
REQ-040 Random scenario: 10,000 cycles of random in_valid, out_ready, flush (1%) and reset (0.5%) against a reference queue model -> zero ordering mismatches and count always <= 2.

Source files
------------

// File: rtl/skid_reg_pkg.sv
// Shared types for the skid register slice.
// State encoding doubles as the occupancy count.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int CNT_W = 2;

  function automatic logic [CNT_W-1:0] state_cnt(state_e s);
    return CNT_W'(s);
  endfunction

endpackage

// File: rtl/skid_reg_if.sv
// Valid/ready bundle for the skid register slice.
// master drives the upstream side, slave is the slice.
interface skid_reg_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/skid_reg_reg_en_rn.sv
// Register with load enable and synchronous
// active-low clear.
module reg_en_rn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid slice: ready is decoded from state
// only, so no combinational path crosses the slice.
module skid_reg
  import skid_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  state_e           state_q;
  state_e           state_d;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_cnt(state_q);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_xfer && out_xfer: begin
              main_en = 1'b1;
            end
            in_xfer && !out_xfer: begin
              skid_en = 1'b1;
              state_d = FULL;
            end
            out_xfer && !in_xfer: begin
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // drain promotes skid into main
          if (out_xfer) begin
            main_d  = skid_q;
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  reg_en_rn #(.WIDTH(WIDTH)) u_main (
    .clk   (CLK),
    .rst_n (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  reg_en_rn #(.WIDTH(WIDTH)) u_skid (
    .clk   (CLK),
    .rst_n (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_skid_reg.sv
// Bench for skid_reg: directed vector table plus a
// queue scoreboard run on every cycle.
module tb_skid_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;

  always #5 clk = ~clk;

  skid_reg_if #(.WIDTH(8)) bus ();

  skid_reg #(.WIDTH(8)) dut (
    .CLK       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_ready (bus.out_ready),
    .count     (count)
  );

  typedef struct {
    logic       r;
    logic       f;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [1:0] cnt;
    logic       ov;
    logic       ir;
    logic       chkd;
    logic [7:0] ed;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  bit         zero_known = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  function automatic vec_t mk(
    logic r, logic f, logic iv, logic [7:0] d,
    logic ordy, logic [1:0] cnt, logic ov,
    logic ir, logic chkd, logic [7:0] ed);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d;
    v.ordy = ordy; v.cnt = cnt; v.ov = ov;
    v.ir = ir; v.chkd = chkd; v.ed = ed;
    return v;
  endfunction

  function automatic void check(
    string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  task automatic sb_check();
    check("sb_count", 32'(count), sb.size());
    check("sb_out_valid", 32'(bus.out_valid),
          32'(sb.size() > 0));
    check("sb_in_ready", 32'(bus.in_ready),
          32'(sb.size() < 2));
    check("count_range", 32'(count <= 2'd2), 1);
    if (sb.size() > 0)
      check("sb_data", 32'(bus.out_data), 32'(sb[0]));
    else if (zero_known)
      check("sb_zero", 32'(bus.out_data), 0);
  endtask

  task automatic step(
    input logic r, input logic f, input logic iv,
    input logic [7:0] d, input logic ordy);
    bit acc;
    bit pop;
    rst_n = r;
    flush = f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    acc = iv && (sb.size() < 2);
    pop = ordy && (sb.size() > 0);
    @(posedge clk);
    if (!r) begin
      sb.delete();
      zero_known = 1'b1;
    end else if (f) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(d);
        zero_known = 1'b0;
      end
    end
    #1;
    sb_check();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // reset held with traffic offered
    vecs.push_back(mk(0,0,1,8'hAA,0, 0,0,1,1,8'h00));
    vecs.push_back(mk(0,0,1,8'hAA,0, 0,0,1,1,8'h00));
    vecs.push_back(mk(1,0,0,8'h00,0, 0,0,1,1,8'h00));
    // streaming
    vecs.push_back(mk(1,0,1,8'h01,1, 1,1,1,1,8'h01));
    vecs.push_back(mk(1,0,1,8'h02,1, 1,1,1,1,8'h02));
    vecs.push_back(mk(1,0,1,8'h03,1, 1,1,1,1,8'h03));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,0,1,0,8'h00));
    // backpressure
    vecs.push_back(mk(1,0,1,8'h10,0, 1,1,1,1,8'h10));
    vecs.push_back(mk(1,0,1,8'h20,0, 2,1,0,1,8'h10));
    vecs.push_back(mk(1,0,1,8'h30,0, 2,1,0,1,8'h10));
    vecs.push_back(mk(1,0,1,8'h30,1, 1,1,1,1,8'h20));
    vecs.push_back(mk(1,0,1,8'h30,1, 1,1,1,1,8'h30));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,0,1,0,8'h00));
    // drain from FULL ignores input
    vecs.push_back(mk(1,0,1,8'h41,0, 1,1,1,1,8'h41));
    vecs.push_back(mk(1,0,1,8'h42,0, 2,1,0,1,8'h41));
    vecs.push_back(mk(1,0,1,8'h55,1, 1,1,1,1,8'h42));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,0,1,0,8'h00));
    // flush from FULL with input offered
    vecs.push_back(mk(1,0,1,8'h61,0, 1,1,1,1,8'h61));
    vecs.push_back(mk(1,0,1,8'h62,0, 2,1,0,1,8'h61));
    vecs.push_back(mk(1,1,1,8'h77,0, 0,0,1,0,8'h00));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,0,1,0,8'h00));
    vecs.push_back(mk(1,1,1,8'h88,1, 0,0,1,0,8'h00));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,0,1,0,8'h00));
    // reset mid-stream beats flush and transfers
    vecs.push_back(mk(1,0,1,8'h91,0, 1,1,1,1,8'h91));
    vecs.push_back(mk(0,1,1,8'h92,1, 0,0,1,1,8'h00));
    vecs.push_back(mk(1,0,0,8'h00,0, 0,0,1,1,8'h00));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].f, vecs[i].iv,
           vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d_count", i),
            32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_out_valid", i),
            32'(bus.out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_in_ready", i),
            32'(bus.in_ready), 32'(vecs[i].ir));
      if (vecs[i].chkd)
        check($sformatf("vec%0d_out_data", i),
              32'(bus.out_data), 32'(vecs[i].ed));
    end

    // hold under backpressure: data must stay put
    step(1, 0, 1, 8'hC1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 8'h00, 0);
      check("hold_stable", 32'(bus.out_data), 32'hC1);
    end
    step(1, 0, 0, 8'h00, 1);

    for (int n = 0; n < 10000; n++) begin
      step(logic'($urandom_range(999) >= 5),
           logic'($urandom_range(999) < 10),
           logic'($urandom_range(1)),
           8'($urandom),
           logic'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
